// File: rtl/sha256_nonce_worker.sv
// SHA-256 compression worker: header block 2 (midstate + tail + nonce) or a 256-bit digest.
// Latency: out_valid rises 64/ROUNDS_PER_CYCLE+1 clocks after the accept edge.
// Backpressure: one job in flight; in_ready only in IDLE, result held until out_ready or abort.
module sha256_nonce_worker #(
  parameter int NONCE_W          = 32,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [7:0][31:0]   in_hi,
  input  logic [2:0][31:0]   in_tail,
  input  logic [NONCE_W-1:0] in_nonce,
  input  logic [7:0][31:0]   in_digest,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0][31:0]   out_hash,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               out_mode
);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
    if (NONCE_W < 1 || NONCE_W > 32) begin : g_bad_nonce
      $error("NONCE_W must be in 1..32");
    end
  endgenerate

  localparam int         R      = ROUNDS_PER_CYCLE;
  localparam logic [5:0] STEP   = 6'(R);
  localparam logic [5:0] LAST_T = 6'(64 - R);

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t               state_q;
  logic [5:0]           rnd_q;
  logic                 mode_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [7:0][31:0]     chain_q;
  logic [7:0][31:0]     wk_q, wk_d;     // a..h at index 0..7
  logic [15:0][31:0]    w_q, w_d;       // w_q[0] is W[t] for the current round
  logic                 out_valid_q;
  logic [7:0][31:0]     out_hash_q;
  logic [NONCE_W-1:0]   out_nonce_q;
  logic                 out_mode_q;

  logic [31:0]          nonce_ext;
  logic [7:0][31:0]     chain_ld;
  logic [15:0][31:0]    msg_ld;
  logic [31:0]          t1, t2, wnew;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_hash  = out_hash_q;
  assign out_nonce = out_nonce_q;
  assign out_mode  = out_mode_q;

  // Padded message block and chaining value for a job presented at the input
  always_comb begin
    nonce_ext = '0;
    nonce_ext[NONCE_W-1:0] = in_nonce;
    msg_ld   = '0;
    chain_ld = in_hi;
    if (in_mode) begin
      chain_ld = IV;
      for (int i = 0; i < 8; i++) msg_ld[i] = in_digest[i];
      msg_ld[8]  = 32'h80000000;
      msg_ld[15] = 32'h00000100;
    end else begin
      for (int i = 0; i < 3; i++) msg_ld[i] = in_tail[i];
      msg_ld[3]  = nonce_ext;
      msg_ld[4]  = 32'h80000000;
      msg_ld[15] = 32'h00000280;
    end
  end

  // R chained rounds; the window always extends by W[t+16] so no t<16 special case is needed
  always_comb begin
    wk_d = wk_q;
    w_d  = w_q;
    t1   = '0;
    t2   = '0;
    wnew = '0;
    for (int r = 0; r < R; r++) begin
      t1 = wk_d[7] + bsig1(wk_d[4]) + ((wk_d[4] & wk_d[5]) ^ (~wk_d[4] & wk_d[6]))
           + K[rnd_q + 6'(r)] + w_d[0];
      t2 = bsig0(wk_d[0]) + ((wk_d[0] & wk_d[1]) ^ (wk_d[0] & wk_d[2]) ^ (wk_d[1] & wk_d[2]));
      wnew = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
      w_d  = {wnew, w_d[15:1]};
      wk_d[7] = wk_d[6];
      wk_d[6] = wk_d[5];
      wk_d[5] = wk_d[4];
      wk_d[4] = wk_d[3] + t1;
      wk_d[3] = wk_d[2];
      wk_d[2] = wk_d[1];
      wk_d[1] = wk_d[0];
      wk_d[0] = t1 + t2;
    end
  end

  // Job sequencing: accept, iterate rounds, add chaining value, hold result until taken or aborted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      nonce_q     <= '0;
      chain_q     <= '0;
      wk_q        <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      out_nonce_q <= '0;
      out_mode_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q  <= in_mode;
            nonce_q <= in_nonce;
            chain_q <= chain_ld;
            wk_q    <= chain_ld;
            w_q     <= msg_ld;
            rnd_q   <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            rnd_q   <= '0;
            state_q <= IDLE;
          end else begin
            wk_q  <= wk_d;
            w_q   <= w_d;
            rnd_q <= rnd_q + STEP;
            if (rnd_q == LAST_T) state_q <= FINAL;
          end
        end
        FINAL: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            for (int i = 0; i < 8; i++) out_hash_q[i] <= chain_q[i] + wk_q[i];
            out_nonce_q <= nonce_q;
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_worker.sv
// Directed bench for sha256_nonce_worker: three instances at 1, 2 and 4 rounds per cycle.
// Known-answer vectors (zero digest, Bitcoin genesis header double hash) plus a reference compressor.
// Checks handshakes, latency, hold under backpressure, abort and asynchronous reset.
module tb_sha256_nonce_worker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             in_mode;
  logic             abort;
  logic [7:0][31:0] in_hi;
  logic [7:0][31:0] in_digest;
  logic [2:0][31:0] in_tail;
  logic [31:0]      in_nonce;
  logic             iv   [3];
  logic             irdy [3];
  logic             ov   [3];
  logic             ordy [3];
  logic             om   [3];
  logic [7:0][31:0] oh   [3];
  logic [31:0]      on   [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256_nonce_worker #(.NONCE_W(32), .ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (iv[g]),
      .in_ready  (irdy[g]),
      .in_mode   (in_mode),
      .in_hi     (in_hi),
      .in_tail   (in_tail),
      .in_nonce  (in_nonce),
      .in_digest (in_digest),
      .abort     (abort),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_hash  (oh[g]),
      .out_nonce (on[g]),
      .out_mode  (om[g])
    );
  end

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // Hash words written H0 first, as printed in references
  function automatic logic [7:0][31:0] to_h(input logic [255:0] x);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[255 - 32*i -: 32];
    return r;
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference compression with the full 64-entry schedule
  function automatic logic [7:0][31:0] ref_compress(input logic [7:0][31:0] hin,
                                                    input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] x, y;
    logic [7:0][31:0] res;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[i];
    for (int t = 0; t < 64; t++) begin
      x = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
        + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      y = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
        + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x;
      v[0] = x + y;
    end
    for (int i = 0; i < 8; i++) res[i] = hin[i] + v[i];
    return res;
  endfunction

  function automatic logic [15:0][31:0] blk0(input logic [2:0][31:0] t, input logic [31:0] n);
    logic [15:0][31:0] b;
    b = '0;
    for (int i = 0; i < 3; i++) b[i] = t[i];
    b[3]  = n;
    b[4]  = 32'h80000000;
    b[15] = 32'h00000280;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Presents one job on instance g, waits for the result, optionally holds and takes it
  task automatic run_job(input int g, input logic md, input logic [31:0] nc, input int hold,
                         input bit take, input string tag,
                         output logic [7:0][31:0] h, output int lat);
    logic busy_ok, stable_ok;
    logic [7:0][31:0] snap;
    in_mode  = md;
    in_nonce = nc;
    iv[g]    = 1'b1;
    chk({tag, "_rdy_in"}, 256'(irdy[g]), 256'd1);
    @(posedge clk); @(negedge clk);
    iv[g]    = 1'b0;
    in_mode  = ~md;
    in_nonce = ~nc;
    lat      = 0;
    busy_ok  = 1'b1;
    while (!ov[g] && lat < 200) begin
      if (irdy[g]) busy_ok = 1'b0;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (irdy[g]) busy_ok = 1'b0;
    chk({tag, "_valid"}, 256'(ov[g]), 256'd1);
    chk({tag, "_busy"}, 256'(busy_ok), 256'd1);
    chk({tag, "_nonce"}, 256'(on[g]), 256'(nc));
    chk({tag, "_mode"}, 256'(om[g]), 256'(md));
    h = oh[g];
    if (hold > 0) begin
      stable_ok = 1'b1;
      snap = oh[g];
      repeat (hold) begin
        @(posedge clk); @(negedge clk);
        if (!ov[g] || oh[g] !== snap || irdy[g]) stable_ok = 1'b0;
      end
      chk({tag, "_hold"}, 256'(stable_ok), 256'd1);
    end
    if (take) begin
      ordy[g] = 1'b1;
      @(posedge clk); @(negedge clk);
      ordy[g] = 1'b0;
      chk({tag, "_taken"}, 256'(ov[g]), 256'd0);
      chk({tag, "_rdy_out"}, 256'(irdy[g]), 256'd1);
    end
  endtask

  initial begin
    logic [7:0][31:0]  h, h1, hprev, mid, iv_h, hz, gen;
    logic [15:0][31:0] blk;
    logic [31:0]       nonces [3];
    logic              saw;
    int                lat;

    iv_h = to_h(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
    hz   = to_h(256'h66687aad_f862bd77_6c8fc18b_8e9f8e20_08971485_6ee233b3_902a591d_0d5f2925);
    gen  = to_h(256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000);

    reset_n = 1'b0; abort = 1'b0; in_mode = 1'b0; in_nonce = '0;
    in_hi = '0; in_tail = '0; in_digest = '0;
    for (int g = 0; g < 3; g++) begin
      iv[g] = 1'b0;
      ordy[g] = 1'b0;
    end
    #12;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_rdy%0d", g), 256'(irdy[g]), 256'd1);
      chk($sformatf("rst_valid%0d", g), 256'(ov[g]), 256'd0);
      chk($sformatf("rst_hash%0d", g), 256'(oh[g]), 256'd0);
      chk($sformatf("rst_nonce%0d", g), 256'(on[g]), 256'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Reference compressor against the "abc" known answer
    blk = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    chk("model_abc", 256'(ref_compress(iv_h, blk)),
        256'(to_h(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad)));

    // Zero digest at 1, 2 and 4 rounds per cycle
    in_digest = '0;
    for (int g = 0; g < 3; g++) begin
      run_job(g, 1'b1, 32'h12345670 + 32'(g), 0, 1'b1, $sformatf("zero_r%0d", 1 << g), h, lat);
      chk($sformatf("zero_hash_r%0d", 1 << g), 256'(h), 256'(hz));
      chk($sformatf("zero_lat_r%0d", 1 << g), 256'(lat), 256'((64 >> g) + 1));
    end

    // Genesis header: block 1 gives the midstate, block 2 is the worker's mode 0
    blk = '0;
    blk[0]  = 32'h01000000;
    blk[9]  = 32'h3ba3edfd; blk[10] = 32'h7a7b12b2; blk[11] = 32'h7ac72c3e;
    blk[12] = 32'h67768f61; blk[13] = 32'h7fc81bc3; blk[14] = 32'h888a5132;
    blk[15] = 32'h3a9fb8aa;
    mid = ref_compress(iv_h, blk);
    in_hi = mid;
    in_tail[0] = 32'h4b1e5e4a; in_tail[1] = 32'h29ab5f49; in_tail[2] = 32'hffff001d;
    run_job(0, 1'b0, 32'h1dac2b7c, 0, 1'b1, "gen1", h1, lat);
    chk("gen1_hash", 256'(h1), 256'(ref_compress(mid, blk0(in_tail, 32'h1dac2b7c))));
    in_digest = h1;
    run_job(2, 1'b1, 32'h1dac2b7c, 0, 1'b1, "gen2", h, lat);
    chk("gen2_hash", 256'(h), 256'(gen));

    // Back-to-back nonces; the last result is held under backpressure for 10 cycles
    nonces[0] = 32'h00000000; nonces[1] = 32'h00000001; nonces[2] = 32'hffffffff;
    for (int k = 0; k < 3; k++) begin
      run_job(0, 1'b0, nonces[k], (k == 2) ? 10 : 0, 1'b1, $sformatf("b2b%0d", k), h, lat);
      chk($sformatf("b2b%0d_hash", k), 256'(h), 256'(ref_compress(mid, blk0(in_tail, nonces[k]))));
    end
    hprev = h;

    // Abort after 30 rounds
    in_mode = 1'b0; in_nonce = 32'h00000005; iv[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      saw |= ov[0];
    end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 256'(irdy[0]), 256'd1);
    chk("abort_hash_kept", 256'(oh[0]), 256'(hprev));
    repeat (70) begin
      saw |= ov[0];
      @(posedge clk); @(negedge clk);
    end
    chk("abort_no_valid", 256'(saw | ov[0]), 256'd0);
    run_job(0, 1'b0, 32'h00000007, 0, 1'b1, "post_abort", h, lat);
    chk("post_abort_hash", 256'(h), 256'(ref_compress(mid, blk0(in_tail, 32'h00000007))));

    // Abort while a result waits in DONE
    in_digest = h1;
    run_job(0, 1'b1, 32'h00000009, 0, 1'b0, "done_abort", h, lat);
    chk("done_abort_hash", 256'(h), 256'(gen));
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("done_abort_valid", 256'(ov[0]), 256'd0);
    chk("done_abort_rdy", 256'(irdy[0]), 256'd1);
    chk("done_abort_kept", 256'(oh[0]), 256'(gen));

    // Asynchronous reset in the middle of ROUND
    in_mode = 1'b0; in_nonce = 32'h00000003; iv[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 256'(irdy[0]), 256'd1);
    chk("mid_rst_valid", 256'(ov[0]), 256'd0);
    chk("mid_rst_hash", 256'(oh[0]), 256'd0);
    chk("mid_rst_nonce", 256'(on[0]), 256'd0);
    chk("mid_rst_mode", 256'(om[0]), 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_job(0, 1'b0, 32'h80000001, 0, 1'b1, "post_rst", h, lat);
    chk("post_rst_hash", 256'(h), 256'(ref_compress(mid, blk0(in_tail, 32'h80000001))));
    chk("post_rst_lat", 256'(lat), 256'd65);
    run_job(2, 1'b0, 32'hdeadbeef, 0, 1'b1, "post_rst_r4", h, lat);
    chk("post_rst_r4_hash", 256'(h), 256'(ref_compress(mid, blk0(in_tail, 32'hdeadbeef))));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
